rx_acknak_gen: RTL and testbench

RX_ACKNAK_GEN -- requirements
Module: rx_acknak_gen

---
 rtl/rx_acknak_gen_pkg.sv | 20 ++
 rtl/rx_acknak_gen_crc.sv | 24 ++
 rtl/rx_acknak_gen.sv | 165 ++++++++++++++++
 tb/tb_rx_acknak_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_acknak_gen_pkg.sv
// Shared constants and types for the receive-side ACK/NAK generator.
// Holds the DLLP encodings, the TLP section count, the CRC-16 parameters and the FSM states.
package rx_acknak_gen_pkg;

   localparam int          SECTIONS = 10;
   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   localparam logic [1:0] DLLP_NONE = 2'b00;
   localparam logic [1:0] DLLP_ACK  = 2'b01;
   localparam logic [1:0] DLLP_NAK  = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2,
      DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/rx_acknak_gen_crc.sv
// One 16-bit section folded into a CRC-16-CCITT register, MSB first, in a single cycle.
module crc16_step
   import rx_acknak_gen_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [15:0] word,
   output logic [15:0] crc_out
);

   logic [15:0] c;
   logic        fb;

   always_comb begin
      c  = crc_in;
      fb = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         fb = c[15] ^ word[i];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ CRC_POLY;
      end
      crc_out = c;
   end

endmodule

// File: rtl/rx_acknak_gen.sv
// Receive-side data link layer: collects TLP sections, checks CRC and sequence number,
// forwards good payloads and keeps one pending ACK/NAK DLLP for the physical layer.
module rx_acknak_gen #(
   parameter int SECTIONS = rx_acknak_gen_pkg::SECTIONS
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      we_i,
   input  logic [15:0]               data_i,
   output logic                      rdy_o,
   output logic [15:0]               rx_data_o,
   output logic                      rx_valid_o,
   output logic                      rx_last_o,
   input  logic                      rx_rdy_i,
   output logic [1:0]                acknak_o,
   output logic [11:0]               acknak_seq_o,
   input  logic                      busy_n,
   output rx_acknak_gen_pkg::state_e dbg_state
);
   import rx_acknak_gen_pkg::*;

   localparam int PAYLOAD = SECTIONS - 2;
   localparam int IW      = $clog2(SECTIONS);
   localparam int RW      = $clog2(PAYLOAD);

   state_e         state, state_nxt;
   logic [IW-1:0]  sec_idx;
   logic [11:0]    seq_rx, next_rcv_seq, seq_diff, prev_seq;
   logic [15:0]    crc, crc_rx, crc_seed, crc_nxt;
   logic           nak_sched;
   logic [1:0]     slot_type;
   logic [11:0]    slot_seq;
   logic [RW-1:0]  rd_idx;
   logic [15:0]    payload [PAYLOAD];
   logic           last_sec, crc_ok, is_good, is_dup;
   logic           load, nak_set;
   logic [1:0]     load_type;
   logic [11:0]    load_seq;

   assign crc_seed = (state == IDLE) ? CRC_INIT : crc;

   crc16_step u_crc (
      .crc_in  (crc_seed),
      .word    (data_i),
      .crc_out (crc_nxt)
   );

   assign last_sec = (sec_idx == IW'(SECTIONS - 1));
   assign seq_diff = next_rcv_seq - seq_rx;
   assign prev_seq = next_rcv_seq - 12'd1;
   assign crc_ok   = (crc_rx == crc);
   assign is_good  = crc_ok && (seq_diff == 12'd0);
   assign is_dup   = crc_ok && (seq_diff != 12'd0) && (seq_diff <= 12'd2048);

   // A duplicate ACK must not displace a pending NAK; only a GOOD TLP may do that.
   always_comb begin
      load      = 1'b0;
      nak_set   = 1'b0;
      load_type = DLLP_NONE;
      load_seq  = 12'd0;
      if (state == CHECK) begin
         if (is_good) begin
            load      = 1'b1;
            load_type = DLLP_ACK;
            load_seq  = seq_rx;
         end else if (is_dup) begin
            if (slot_type != DLLP_NAK) begin
               load      = 1'b1;
               load_type = DLLP_ACK;
               load_seq  = prev_seq;
            end
         end else if (!nak_sched) begin
            load      = 1'b1;
            nak_set   = 1'b1;
            load_type = DLLP_NAK;
            load_seq  = prev_seq;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (we_i) state_nxt = RECV;
         RECV:    if (we_i && last_sec) state_nxt = CHECK;
         CHECK:   state_nxt = is_good ? DRAIN : IDLE;
         DRAIN:   if (rx_rdy_i && rd_idx == RW'(PAYLOAD - 1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) state <= IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         sec_idx      <= '0;
         seq_rx       <= 12'd0;
         next_rcv_seq <= 12'd0;
         crc          <= CRC_INIT;
         crc_rx       <= 16'd0;
         nak_sched    <= 1'b0;
         rd_idx       <= '0;
      end else begin
         case (state)
            IDLE: if (we_i) begin
               seq_rx  <= data_i[11:0];
               crc     <= crc_nxt;
               sec_idx <= IW'(1);
            end
            RECV: if (we_i) begin
               if (last_sec) begin
                  crc_rx  <= data_i;
                  sec_idx <= '0;
               end else begin
                  crc     <= crc_nxt;
                  sec_idx <= sec_idx + IW'(1);
               end
            end
            CHECK: begin
               if (is_good) begin
                  next_rcv_seq <= next_rcv_seq + 12'd1;
                  nak_sched    <= 1'b0;
               end else if (nak_set) begin
                  nak_sched    <= 1'b1;
               end
               rd_idx <= '0;
               crc    <= CRC_INIT;
            end
            DRAIN: if (rx_rdy_i) rd_idx <= rd_idx + RW'(1);
            default: ;
         endcase
      end
   end

   // A load in the same cycle as busy_n wins: the old DLLP is consumed, the new one stays.
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         slot_type <= DLLP_NONE;
         slot_seq  <= 12'd0;
      end else if (load) begin
         slot_type <= load_type;
         slot_seq  <= load_seq;
      end else if (busy_n) begin
         slot_type <= DLLP_NONE;
         slot_seq  <= 12'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (state == RECV && we_i && !last_sec)
         payload[RW'(sec_idx - IW'(1))] <= data_i;
   end

   assign rdy_o        = (state == IDLE) || (state == RECV);
   assign rx_valid_o   = (state == DRAIN);
   assign rx_data_o    = rx_valid_o ? payload[rd_idx] : 16'd0;
   assign rx_last_o    = rx_valid_o && (rd_idx == RW'(PAYLOAD - 1));
   assign acknak_o     = slot_type;
   assign acknak_seq_o = slot_seq;
   assign dbg_state    = state;

endmodule

// File: tb/tb_rx_acknak_gen.sv
// Bench for rx_acknak_gen: directed TLP scenarios plus a few random payloads, payload
// words checked against an expected queue, DLLP slot checked after each TLP.
module tb_rx_acknak_gen;
   import rx_acknak_gen_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        we_i;
   logic [15:0] data_i;
   logic        rdy_o;
   logic [15:0] rx_data_o;
   logic        rx_valid_o;
   logic        rx_last_o;
   logic        rx_rdy_i;
   logic [1:0]  acknak_o;
   logic [11:0] acknak_seq_o;
   logic        busy_n;
   state_e      dbg_state;

   int          vectors = 0;
   int          errors  = 0;
   int          sent_cnt = 0;
   logic [11:0] model_next = 12'd0;
   logic [16:0] exp_q[$];

   rx_acknak_gen #(.SECTIONS(10)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .we_i         (we_i),
      .data_i       (data_i),
      .rdy_o        (rdy_o),
      .rx_data_o    (rx_data_o),
      .rx_valid_o   (rx_valid_o),
      .rx_last_o    (rx_last_o),
      .rx_rdy_i     (rx_rdy_i),
      .acknak_o     (acknak_o),
      .acknak_seq_o (acknak_seq_o),
      .busy_n       (busy_n),
      .dbg_state    (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [15:0] w);
      logic [15:0] r;
      r = c ^ w;
      for (int i = 0; i < 16; i++)
         r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   // transaction layer back-pressure
   initial begin
      rx_rdy_i = 1'b1;
      forever begin
         @(posedge clk);
         #1 rx_rdy_i = ($urandom_range(0, 3) != 0);
      end
   end

   // scoreboard and DLLP consumption counter
   always @(negedge clk) begin
      if (!reset_n && busy_n && acknak_o != 2'b00) sent_cnt++;
      if (!reset_n && rx_valid_o && rx_rdy_i) begin
         if (exp_q.size() == 0) check("rx_unexpected", 32'(rx_data_o), 32'hDEAD);
         else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            check("rx_data", 32'(rx_data_o), 32'(e[15:0]));
            check("rx_last", 32'(rx_last_o), 32'(e[16]));
         end
      end
   end

   // driver: n_sec < 10 stops mid-TLP; returns one cycle after the last section (CHECK)
   task automatic send_tlp(input logic [11:0] seq, input logic [15:0] base,
                           input bit corrupt, input int n_sec);
      logic [15:0] w [10];
      logic [15:0] c;
      logic [11:0] diff;
      bit          ok;
      w[0] = {4'b0, seq};
      for (int i = 1; i <= 8; i++) w[i] = base + 16'(i - 1);
      c = 16'hFFFF;
      for (int i = 0; i <= 8; i++) c = crc_model(c, w[i]);
      w[9] = corrupt ? (c ^ 16'h0100) : c;
      for (int s = 0; s < n_sec; s++) begin
         repeat ($urandom_range(0, 1)) tick();
         ok = 1'b0;
         for (int k = 0; k < 100; k++) begin
            if (rdy_o) begin ok = 1'b1; break; end
            tick();
         end
         if (!ok) check("rdy_timeout", 32'(rdy_o), 32'd1);
         we_i   = 1'b1;
         data_i = w[s];
         tick();
         we_i   = 1'b0;
      end
      if (n_sec == 10) begin
         diff = model_next - seq;
         if (!corrupt && diff == 12'd0) begin
            for (int i = 1; i <= 8; i++) exp_q.push_back({(i == 8), w[i]});
            model_next = model_next + 12'd1;
         end
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (dbg_state == IDLE && exp_q.size() == 0) begin ok = 1'b1; break; end
         tick();
      end
      if (!ok) check("idle_timeout", 32'(dbg_state), 32'(IDLE));
   endtask

   task automatic check_slot(input string tag, input logic [1:0] t, input logic [11:0] s);
      check({tag, "_type"}, 32'(acknak_o), 32'(t));
      check({tag, "_seq"}, 32'(acknak_seq_o), 32'(s));
   endtask

   task automatic consume();
      busy_n = 1'b1;
      tick();
      busy_n = 1'b0;
      check_slot("consumed", 2'b00, 12'd0);
   endtask

   initial begin
      int sent0;
      logic [11:0] rs;
      reset_n = 1'b1;
      we_i    = 1'b0;
      data_i  = 16'd0;
      busy_n  = 1'b0;
      repeat (3) tick();
      check("rst_rdy", 32'(rdy_o), 32'd1);
      check("rst_valid", 32'(rx_valid_o), 32'd0);
      check("rst_last", 32'(rx_last_o), 32'd0);
      check("rst_data", 32'(rx_data_o), 32'd0);
      check_slot("rst", 2'b00, 12'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      reset_n = 1'b0;
      tick();

      // first good TLP
      send_tlp(12'd0, 16'h0001, 1'b0, 10);
      wait_idle();
      check_slot("good0", 2'b01, 12'd0);
      check("next_after0", 32'(dut.next_rcv_seq), 32'd1);
      consume();

      // bad TLP, then a second bad one while the NAK is scheduled
      send_tlp(12'd1, 16'h0021, 1'b1, 10);
      wait_idle();
      check_slot("bad1", 2'b10, 12'd0);
      consume();
      send_tlp(12'd1, 16'h0031, 1'b1, 10);
      wait_idle();
      check_slot("bad2", 2'b00, 12'd0);

      // duplicate, then the good retransmission
      send_tlp(12'd0, 16'h0041, 1'b0, 10);
      wait_idle();
      check_slot("dup0", 2'b01, 12'd0);
      consume();
      send_tlp(12'd1, 16'h0011, 1'b0, 10);
      wait_idle();
      check_slot("good1", 2'b01, 12'd1);
      consume();

      // ACK coalescing while the physical layer is busy
      for (int i = 2; i <= 4; i++) begin
         send_tlp(12'(i), 16'(i * 16'h0100), 1'b0, 10);
         wait_idle();
         check_slot("coalesce", 2'b01, 12'(i));
      end
      sent0 = sent_cnt;
      consume();
      repeat (3) tick();
      check("one_sent", 32'(sent_cnt - sent0), 32'd1);

      // NAK replaces ACK, duplicate cannot replace NAK, GOOD load beats busy_n
      send_tlp(12'd5, 16'h0500, 1'b0, 10);
      wait_idle();
      check_slot("good5", 2'b01, 12'd5);
      send_tlp(12'd6, 16'h0600, 1'b1, 10);
      wait_idle();
      check_slot("nak_over_ack", 2'b10, 12'd5);
      send_tlp(12'd5, 16'h0700, 1'b0, 10);
      wait_idle();
      check_slot("dup_keeps_nak", 2'b10, 12'd5);
      sent0 = sent_cnt;
      send_tlp(12'd6, 16'h0800, 1'b0, 10);
      check("at_check", 32'(dbg_state), 32'(CHECK));
      busy_n = 1'b1;
      tick();
      busy_n = 1'b0;
      check_slot("load_wins", 2'b01, 12'd6);
      check("collide_sent", 32'(sent_cnt - sent0), 32'd1);
      wait_idle();
      consume();

      // asynchronous reset in the middle of a TLP
      send_tlp(12'd7, 16'h0900, 1'b0, 5);
      check("mid_state", 32'(dbg_state), 32'(RECV));
      #2 reset_n = 1'b1;
      #1;
      check("arst_state", 32'(dbg_state), 32'(IDLE));
      check("arst_rdy", 32'(rdy_o), 32'd1);
      check("arst_valid", 32'(rx_valid_o), 32'd0);
      check_slot("arst", 2'b00, 12'd0);
      tick();
      reset_n = 1'b0;
      model_next = 12'd0;
      exp_q.delete();
      tick();
      send_tlp(12'd0, 16'h0100, 1'b0, 10);
      wait_idle();
      check_slot("post_rst", 2'b01, 12'd0);
      consume();

      // random payloads
      for (int k = 0; k < 4; k++) begin
         rs = model_next;
         send_tlp(rs, 16'($urandom_range(0, 65535)), 1'b0, 10);
         wait_idle();
         check_slot("rand", 2'b01, rs);
         consume();
      end

      // sequence number wrap
      force dut.next_rcv_seq = 12'hFFF;
      tick();
      release dut.next_rcv_seq;
      model_next = 12'hFFF;
      tick();
      check("forced_next", 32'(dut.next_rcv_seq), 32'hFFF);
      send_tlp(12'hFFF, 16'hA000, 1'b0, 10);
      wait_idle();
      check_slot("wrap_ack", 2'b01, 12'hFFF);
      check("wrap_next", 32'(dut.next_rcv_seq), 32'd0);
      consume();
      send_tlp(12'd2, 16'hB000, 1'b0, 10);
      wait_idle();
      check_slot("ahead_nak", 2'b10, 12'hFFF);

      repeat (5) tick();
      check("q_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
